// File: rtl/controller_sequencer.sv
// controller_sequencer: microstep sequencer for the microcode ROM with flag latching,
// halt/single-step control, overrun watchdog and retired-instruction counter.
module controller_sequencer #(
    parameter int MAX_UOP  = 6,
    parameter int IDLE_UOP = 7,
    parameter int IC_WIDTH = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                RESET_uOP,
    input  logic                READ_FLAGS,
    input  logic                ALU_ZERO,
    input  logic                ALU_COUT,
    input  logic                HALT,
    input  logic                STEP,
    input  logic                CLR_FAULT,
    output logic [2:0]          uOP,
    output logic                ZERO_FLAG,
    output logic                COUT_FLAG,
    output logic                HALTED,
    output logic                FAULT,
    output logic [IC_WIDTH-1:0] INSTR_COUNT
);
    localparam logic [2:0] IDLE_U = 3'(IDLE_UOP);
    localparam logic [2:0] MAX_U  = 3'(MAX_UOP);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_t;
    state_t     state, state_nx;
    logic [2:0] uop_nx;
    logic       stepping, stepping_nx, step_q, retire;
    always_comb begin
        state_nx    = state;
        uop_nx      = uOP;
        stepping_nx = stepping;
        retire      = 1'b0;
        case (state)
            S_IDLE: begin
                state_nx = HALT ? S_HALT : S_RUN;
                uop_nx   = HALT ? IDLE_U : 3'd0;
            end
            S_RUN: begin
                if (RESET_uOP) begin
                    retire      = 1'b1;
                    state_nx    = (HALT || stepping) ? S_HALT : S_RUN;
                    uop_nx      = (HALT || stepping) ? IDLE_U : 3'd0;
                    stepping_nx = 1'b0;
                end else if (uOP == MAX_U) begin
                    state_nx    = S_FAULT;
                    uop_nx      = IDLE_U;
                    stepping_nx = 1'b0;
                end else begin
                    uop_nx = uOP + 3'd1;
                end
            end
            S_HALT: begin
                // a fresh STEP edge wins over a simultaneous HALT release
                if ((STEP && !step_q) || !HALT) begin
                    state_nx    = S_RUN;
                    uop_nx      = 3'd0;
                    stepping_nx = STEP && !step_q;
                end
            end
            S_FAULT: state_nx = CLR_FAULT ? S_HALT : S_FAULT;
            default: begin
                state_nx = S_IDLE;
                uop_nx   = IDLE_U;
            end
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            uOP         <= IDLE_U;
            stepping    <= 1'b0;
            step_q      <= 1'b0;
            ZERO_FLAG   <= 1'b0;
            COUT_FLAG   <= 1'b0;
            INSTR_COUNT <= '0;
        end else begin
            state    <= state_nx;
            uOP      <= uop_nx;
            stepping <= stepping_nx;
            step_q   <= STEP;
            if (READ_FLAGS) begin
                ZERO_FLAG <= ALU_ZERO;
                COUT_FLAG <= ALU_COUT;
            end
            if (retire) INSTR_COUNT <= INSTR_COUNT + 1'b1;
        end
    end
    assign HALTED = (state == S_HALT);
    assign FAULT  = (state == S_FAULT);
endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- Drives the microstep index `uOP` into the microcode controller ROM.
- Consumes the ROM's `RESET_uOP` and `READ_FLAGS` strobes and latches the ALU flags the ROM branches on.
- Adds halt/single-step control, a runaway-microprogram watchdog and a retired-instruction counter.
- Sits between the ROM, the ALU and the front-panel/debug logic.

Parameters:
- MAX_UOP, 6: highest legal microstep index; reaching it without `RESET_uOP` is a fault.
- IDLE_UOP, 7: microstep value presented while in reset, halted or faulted; the ROM decodes it as the all-quiet state.
- IC_WIDTH, 16: width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- RESET_uOP  in  1  from ROM: current microstep is the last of the instruction.
- READ_FLAGS  in  1  from ROM: capture the ALU flags this cycle.
- ALU_ZERO  in  1  ALU zero result (combinational).
- ALU_COUT  in  1  ALU carry out (combinational).
- HALT  in  1  level: stop at the next instruction boundary.
- STEP  in  1  while halted, a rising edge runs exactly one instruction.
- CLR_FAULT  in  1  clears the sticky fault and resumes.
- uOP  out  3  microstep index to ROM.
- ZERO_FLAG  out  1  latched zero flag to ROM.
- COUT_FLAG  out  1  latched carry flag to ROM.
- HALTED  out  1  high while parked at `IDLE_UOP` due to halt.
- FAULT  out  1  sticky: a microprogram overran `MAX_UOP`.
- INSTR_COUNT  out  IC_WIDTH  number of retired instructions.

Behaviour:

Reset (synchronous, overrides everything):
- `uOP` = `IDLE_UOP`.
- `ZERO_FLAG` = 0, `COUT_FLAG` = 0, `FAULT` = 0, `HALTED` = 0, `INSTR_COUNT` = 0.
- STEP edge register = 0.
- State = `IDLE`.
- Reset mid-instruction abandons the instruction; it is not counted.

States:
- `IDLE` (`uOP` = `IDLE_UOP`): the cycle after reset deasserts, go to `RUN` with `uOP` = 0, unless `HALT` = 1, in which case go to `HALT`.
- `RUN`, evaluated each cycle in this priority order:
  - `RESET_uOP` = 1: the instruction retires; `INSTR_COUNT` increments (wraps modulo 2^IC_WIDTH). Next `uOP` = 0, unless `HALT` = 1 or a step is in progress, in which case go to `HALT` with `uOP` = `IDLE_UOP`.
  - `RESET_uOP` = 0 and `uOP` = `MAX_UOP`: go to `FAULT`; `FAULT` = 1; `uOP` = `IDLE_UOP`; no count.
  - Otherwise: `uOP` increments by 1.
- `HALT`: `HALTED` = 1; `uOP` = `IDLE_UOP`.
  - A `STEP` rising edge (STEP = 1 and registered previous STEP = 0) starts one instruction: `uOP` = 0, `HALTED` = 0, and the step-in-progress bit is set.
  - `HALT` falling to 0 resumes free-running: `uOP` = 0 next cycle.
  - The step-in-progress bit is cleared on that instruction's `RESET_uOP`; the sequencer then returns to `HALT` regardless of the `HALT` level that cycle.
- `FAULT`: holds `uOP` = `IDLE_UOP`.
  - `CLR_FAULT` = 1 clears `FAULT` and moves to `HALT`, so software inspects before resuming.
  - `STEP` and `HALT` are ignored while in `FAULT`.

Flags:
- On any cycle with `READ_FLAGS` = 1, `ZERO_FLAG` <= `ALU_ZERO` and `COUT_FLAG` <= `ALU_COUT`; the last capture wins.
- Flags hold otherwise, including across halt and fault; only reset clears them.

Boundary and timing rules:
- `HALT` asserted mid-instruction never truncates it; it takes effect only at `RESET_uOP`.
- `RESET_uOP` with `uOP` = `MAX_UOP` is a legal retire, not a fault.
- `READ_FLAGS` and `RESET_uOP` in the same cycle: both actions occur.
- `STEP` held high yields only one instruction; it must drop and rise again for the next.
- A `STEP` edge outside `HALT` state is discarded, but the edge register still tracks the level.
- `uOP` is registered; the ROM sees the new value one cycle after the decision.

Test Plan:
- Release reset with `HALT` = 0 and drive `RESET_uOP` at `uOP` = 3 each instruction -> `uOP` sequence 7,0,1,2,3,0,1,2,3,0; `INSTR_COUNT` = 2 after the second retire.
- `READ_FLAGS` at `uOP` 4 with ALU_ZERO = 1, ALU_COUT = 0, then at `uOP` 5 with ALU_ZERO = 0, ALU_COUT = 1 -> final `ZERO_FLAG` = 0, `COUT_FLAG` = 1, held through the next instruction.
- Assert `HALT` at `uOP` = 1 with retire at `uOP` 3 -> `uOP` 2,3,7,7…; `HALTED` = 1. Pulse `STEP` -> exactly one 0..3 pass, then back to 7; `INSTR_COUNT` +1.
- Never assert `RESET_uOP` -> `uOP` 0..6 then 7; `FAULT` = 1 and stays. `CLR_FAULT` -> `FAULT` = 0, `HALTED` = 1.
- Assert `RESET` at `uOP` = 2 mid-instruction -> next cycle `uOP` = 7, flags 0, `INSTR_COUNT` = 0, then `uOP` = 0.
- Preload `INSTR_COUNT` to all-ones via retires with IC_WIDTH = 4 (15 retires) -> the 16th retire wraps it to 0.
